// File: rtl/switch_debouncer.sv
// Slide-switch conditioning: two-flop synchronizer, shared sample-tick prescaler,
// per-bit stability counters, registered debounced levels and one-cycle edge pulses.
module switch_debouncer #(
    parameter int WIDTH        = 16,
    parameter int TICK_DIV     = 100000,
    parameter int STABLE_TICKS = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] sw,
    output logic [WIDTH-1:0] sw_db,
    output logic [WIDTH-1:0] sw_rise,
    output logic [WIDTH-1:0] sw_fall
);

    localparam int PW = $clog2(TICK_DIV);
    localparam int CW = $clog2(STABLE_TICKS + 1);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [CW-1:0] CNT_LAST   = CW'(STABLE_TICKS - 1);

    logic [WIDTH-1:0] s1;
    logic [WIDTH-1:0] s2;
    logic [PW-1:0]    presc;
    logic             tick;
    logic [CW-1:0]    cnt [WIDTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= sw;
            s2 <= s1;
        end
    end

    always_comb begin
        tick = (presc == PRESC_LAST);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            presc <= '0;
        end else if (tick) begin
            presc <= '0;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    // A bit only advances its count on ticks where the synchronized level
    // disagrees with the accepted one; any agreeing tick restarts it.
    always_ff @(posedge clk) begin
        if (reset) begin
            sw_db   <= '0;
            sw_rise <= '0;
            sw_fall <= '0;
            for (int unsigned i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sw_rise <= '0;
            sw_fall <= '0;
            if (tick) begin
                for (int unsigned i = 0; i < WIDTH; i++) begin
                    if (s2[i] == sw_db[i]) begin
                        cnt[i] <= '0;
                    end else if (cnt[i] == CNT_LAST) begin
                        cnt[i]     <= '0;
                        sw_db[i]   <= s2[i];
                        sw_rise[i] <= s2[i];
                        sw_fall[i] <= ~s2[i];
                    end else begin
                        cnt[i] <= cnt[i] + 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_switch_debouncer.sv
// Randomized and directed bench for switch_debouncer; a tick-window reference model
// feeds a scoreboard queue that a separate monitor drains every cycle.
`timescale 10ns/1ns
module tb_switch_debouncer;

    localparam int W  = 16;
    localparam int TD = 4;
    localparam int ST = 3;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [W-1:0] sw = '0;
    logic [W-1:0] sw_db, sw_rise, sw_fall;

    switch_debouncer #(
        .WIDTH(W),
        .TICK_DIV(TD),
        .STABLE_TICKS(ST)
    ) dut (
        .clk(clk),
        .reset(reset),
        .sw(sw),
        .sw_db(sw_db),
        .sw_rise(sw_rise),
        .sw_fall(sw_fall)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] db;
        logic [W-1:0] rise;
        logic [W-1:0] fall;
    } resp_t;

    resp_t exp_q[$];
    int checks = 0;
    int passed = 0;

    // Reference model: raw sw history per edge, list of levels seen at each tick,
    // and per bit the tick index of its last accepted change.
    logic [W-1:0] sw_hist[$];
    logic [W-1:0] tick_samp[$];
    int           last_acc[W];
    logic [W-1:0] m_db = '0;
    int           edge_n = 0;

    task automatic model_edge(input logic r, input logic [W-1:0] v);
        resp_t        x;
        logic [W-1:0] s2v;
        int           n;
        bit           all_new;
        x = '0;
        if (r) begin
            sw_hist.delete();
            tick_samp.delete();
            m_db   = '0;
            edge_n = 0;
            foreach (last_acc[i]) last_acc[i] = 0;
        end else begin
            edge_n++;
            // level the synchronizer presents at this edge: sw from two edges earlier
            s2v = (edge_n >= 3) ? sw_hist[edge_n-3] : '0;
            sw_hist.push_back(v);
            if (edge_n % TD == 0) begin
                tick_samp.push_back(s2v);
                n = tick_samp.size();
                for (int i = 0; i < W; i++) begin
                    if (n - last_acc[i] >= ST) begin
                        all_new = 1'b1;
                        for (int k = 1; k <= ST; k++)
                            if (tick_samp[n-k][i] == m_db[i]) all_new = 1'b0;
                        if (all_new) begin
                            m_db[i] = ~m_db[i];
                            if (m_db[i]) x.rise[i] = 1'b1;
                            else         x.fall[i] = 1'b1;
                            last_acc[i] = n;
                        end
                    end
                end
            end
            x.db = m_db;
        end
        exp_q.push_back(x);
    endtask

    // Monitor: every cycle the DUT presents a new output word.
    initial begin
        resp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if ({sw_db, sw_rise, sw_fall} === e) passed++;
                else $display("FAIL scoreboard t=%0t db=%h exp %h rise=%h exp %h fall=%h exp %h",
                              $time, sw_db, e.db, sw_rise, e.rise, sw_fall, e.fall);
            end
        end
    end

    // Per-phase observations for the directed checks.
    int           ph_edges, ph_db_changes, first_hit, ph_rise_edges, ph_fall_edges;
    logic [W-1:0] ph_rise_or, ph_fall_or, ph_last_rise, ph_last_fall, ph_prev_db;
    logic [W-1:0] watch_mask, watch_val;
    bit           any_nz;

    task automatic phase_start(input logic [W-1:0] mask, input logic [W-1:0] val);
        ph_edges = 0; ph_db_changes = 0; first_hit = 0;
        ph_rise_edges = 0; ph_fall_edges = 0;
        ph_rise_or = '0; ph_fall_or = '0; ph_last_rise = '0; ph_last_fall = '0;
        ph_prev_db = sw_db; watch_mask = mask; watch_val = val; any_nz = 1'b0;
    endtask

    task automatic cyc(input logic r, input logic [W-1:0] v);
        @(negedge clk);
        reset = r;
        sw    = v;
        @(posedge clk);
        model_edge(r, v);
        #1;
        ph_edges++;
        if (sw_db != ph_prev_db) ph_db_changes++;
        if (first_hit == 0 && (sw_db & watch_mask) == (watch_val & watch_mask)) first_hit = ph_edges;
        if (sw_rise != '0) begin ph_rise_edges++; ph_last_rise = sw_rise; end
        if (sw_fall != '0) begin ph_fall_edges++; ph_last_fall = sw_fall; end
        ph_rise_or |= sw_rise;
        ph_fall_or |= sw_fall;
        if ({sw_db, sw_rise, sw_fall} != '0) any_nz = 1'b1;
        ph_prev_db = sw_db;
    endtask

    task automatic chk(input string nm, input int act, input int lo, input int hi);
        checks++;
        if (act >= lo && act <= hi) passed++;
        else $display("FAIL %s got %0d want %0d..%0d", nm, act, lo, hi);
    endtask

    initial begin
        logic [W-1:0] v;
        repeat (3) cyc(1'b1, '0);

        phase_start('1, '0);
        repeat (20) cyc(1'b1, '1);
        chk("reset_hold_outputs_zero", int'(any_nz), 0, 0);
        repeat (20) cyc(1'b0, '0);

        phase_start(16'h0001, 16'h0001);
        repeat (20) cyc(1'b0, 16'h0001);
        chk("rise_latency", first_hit, 11, 14);
        chk("rise_pulse_count", ph_rise_edges, 1, 1);
        chk("rise_pulse_value", int'(ph_last_rise), 1, 1);
        chk("rise_no_fall", int'(ph_fall_or), 0, 0);

        phase_start(16'h0002, 16'h0002);
        for (int c = 0; c < 60; c++)
            cyc(1'b0, 16'h0001 | (((c / 5) % 2 == 0) ? 16'h0002 : 16'h0000));
        repeat (20) cyc(1'b0, 16'h0001);
        chk("bounce_db_stays_low", first_hit, 0, 0);
        chk("bounce_no_pulse", int'(ph_rise_or[1] | ph_fall_or[1]), 0, 0);

        phase_start(16'h0001, 16'h0000);
        repeat (20) cyc(1'b0, 16'h0000);
        chk("fall_latency", first_hit, 1, 14);
        chk("fall_pulse_count", ph_fall_edges, 1, 1);
        chk("fall_pulse_value", int'(ph_last_fall), 1, 1);
        chk("fall_no_rise", int'(ph_rise_or), 0, 0);

        phase_start('1, 16'hA5A5);
        repeat (20) cyc(1'b0, 16'hA5A5);
        chk("parallel_db_single_edge", ph_db_changes, 1, 1);
        chk("parallel_db_value", int'(sw_db), 'hA5A5, 'hA5A5);
        chk("parallel_rise_count", ph_rise_edges, 1, 1);
        chk("parallel_rise_value", int'(ph_last_rise), 'hA5A5, 'hA5A5);

        repeat (3) cyc(1'b1, '0);
        repeat (8) cyc(1'b0, 16'h0004);
        repeat (2) cyc(1'b1, 16'h0004);
        chk("midcount_reset_outputs_zero", int'({sw_db, sw_rise, sw_fall} != '0), 0, 0);
        phase_start(16'h0004, 16'h0004);
        repeat (16) cyc(1'b0, 16'h0004);
        chk("midcount_rise_edge", first_hit, 12, 12);
        chk("midcount_rise_count", ph_rise_edges, 1, 1);

        v = '0;
        for (int c = 0; c < 1200; c++) begin
            if ($urandom_range(0, 3) == 0) v ^= W'($urandom & $urandom & $urandom);
            cyc(($urandom_range(0, 299) == 0), v);
        end
        repeat (30) cyc(1'b0, v);

        @(posedge clk);
        #3;
        chk("scoreboard_drained", exp_q.size(), 0, 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/switch_debouncer.md
# switch_debouncer

Front-end conditioning stage for the board's slide switches. It synchronizes the raw asynchronous `sw` inputs into the `clk` domain, debounces each bit independently against a shared sample tick, and drives clean levels plus one-cycle edge pulses. Its outputs feed the switch-to-LED logic in `top` in place of raw `sw`, so downstream logic sees glitch-free inputs.

## Interface
- `WIDTH`, 16: number of switch bits.
- `TICK_DIV`, 100000: clock cycles per sample tick (1 ms at 100 MHz). Must be at least 2.
- `STABLE_TICKS`, 4: consecutive ticks a new level must persist before it is accepted. Must be at least 1.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `sw`  in  WIDTH: raw asynchronous switch inputs.
- `sw_db`  out  WIDTH: debounced switch levels, registered.
- `sw_rise`  out  WIDTH: one-cycle pulse on each bit whose `sw_db` just went 0→1.
- `sw_fall`  out  WIDTH: one-cycle pulse on each bit whose `sw_db` just went 1→0.

## Operation
- Synchronizer: two flops per bit (`s1 <= sw`, `s2 <= s1`). Only `s2` is used downstream.
- Prescaler: counter of width $clog2(TICK_DIV).
  - Counts 0 to TICK_DIV-1, then wraps to 0.
  - Internal `tick` = (prescaler == TICK_DIV-1). It is combinational and high for exactly 1 of every TICK_DIV cycles.
- Per-bit stability counter `cnt[i]`, width $clog2(STABLE_TICKS+1). It updates only on edges where `tick` is high:
  - If `s2[i] == sw_db[i]`: `cnt[i] <= 0`.
  - Else if `cnt[i] == STABLE_TICKS-1`: `sw_db[i] <= s2[i]` and `cnt[i] <= 0`. `sw_rise[i]` or `sw_fall[i]` is set according to the new level.
  - Else: `cnt[i] <= cnt[i]+1`.
- On cycles without a tick, `cnt` and `sw_db` hold.
- Effect: a new level is accepted on the STABLE_TICKS-th consecutive tick that sees it. Any tick that sees agreement restarts the count.
- `sw_rise` and `sw_fall` are registered and default to 0 every cycle. They are never both high on the same bit. Multiple bits may pulse on the same cycle.
- Bits are fully independent. Only the prescaler is shared.

## Timing
- Reset (`reset` high at an edge): `s1`, `s2`, prescaler, all `cnt`, `sw_db`, `sw_rise` and `sw_fall` all become 0.
  - Outputs stay 0 while reset is held, regardless of `sw`.
  - The first tick occurs on the TICK_DIV-th edge after reset deasserts.
- Latency from a step on `sw[i]` (setup met) to `sw_db[i]`:
  - `s2` reflects the step after 2 edges.
  - The update then lands between 2+(STABLE_TICKS-1)·TICK_DIV+1 and 2+STABLE_TICKS·TICK_DIV edges.
- Pulses assert on the same edge that `sw_db` changes and clear on the next edge.
- Reset mid-count discards the partial count. After release, a held changed input needs the full STABLE_TICKS ticks again.
- A bounce window shorter than one tick period can be missed entirely. This is intended.
- A bit that toggles with a half-period of at most (STABLE_TICKS-1)·TICK_DIV cycles never changes `sw_db`.
- Sim setting for all tests below: TICK_DIV=4, STABLE_TICKS=3, timescale 10ns/1ns.

## Test plan
- **Reset hold:** `reset`=1, `sw`=16'hFFFF for 20 cycles -> `sw_db`, `sw_rise` and `sw_fall` are 16'h0000 throughout.
- **Clean rise:** from steady 0, `sw[0]` 0→1 and held -> `sw_db[0]`=1 no earlier than 11 and no later than 14 edges after the change. `sw_rise` = 16'h0001 for exactly one cycle, on the same edge. `sw_fall` stays 0.
- **Bounce reject:** `sw[1]` toggles every 5 cycles for 60 cycles, then settles at 0 -> `sw_db[1]` stays 0, and bit 1 of `sw_rise` and `sw_fall` never pulses.
- **Clean fall:** after the rise test, `sw[0]` 1→0 and held -> `sw_db[0]`=0 within 14 edges. `sw_fall` = 16'h0001 for one cycle. No `sw_rise` pulse.
- **Parallel bits:** `sw` 16'h0000→16'hA5A5 in one cycle -> `sw_db` becomes 16'hA5A5 on a single edge. `sw_rise` = 16'hA5A5 for one cycle.
- **Reset mid-count:** `sw[2]`=1, then assert `reset` one cycle after the 2nd tick -> all outputs 0. After release with `sw[2]` still 1, `sw_db[2]` rises only on the 3rd tick after release (edge 12).
